// File: rtl/updown_counter_wb_if.sv
// Wishbone classic slave bundle for updown_counter_wb.
// The master drives the request side; the slave returns ack and read data.
interface updown_counter_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/updown_counter_wb.sv
// Wishbone-mapped up/down counter with limit, wrap interrupt and optional tick prescaler.
// Define UPDOWN_PRESCALER_EN to enable the 16-bit PRESCALE register at offset 5.
module updown_counter_wb #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    updown_counter_wb_if.slave   wbs,
    output logic [15:0]          io_out,
    output logic [15:0]          io_oeb,
    output logic [2:0]           user_irq
);
    localparam logic [26:0]      BASE_HI = BASE_ADR[31:5];
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_LOAD     = 3'd1;
    localparam logic [2:0] OFF_LIMIT    = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_COUNT    = 3'd4;
    localparam logic [2:0] OFF_PRESCALE = 3'd5;

    logic             r_ack;
    logic [31:0]      r_dat;
    logic [2:0]       r_ctrl;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_count;
    logic             r_wrap;

    logic             w_req;
    logic             w_wr;
    logic [2:0]       w_off;
    logic [31:0]      w_lane_mask;
    logic [31:0]      w_ctrl_wr;
    logic [31:0]      w_limit_wr;
    logic [31:0]      w_load_wr;
    logic             w_wr_ctrl;
    logic             w_wr_load;
    logic             w_wr_limit;
    logic             w_w1c;
    logic             w_tick;
    logic [31:0]      w_prescale_rd;
    logic [31:0]      w_rd_data;
    logic [CNT_W-1:0] w_count_next;
    logic             w_wrap_set;
    logic [31:0]      w_count32;

    // A request is only accepted while ack is low, so acks can never be back-to-back.
    assign w_req = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:5] == BASE_HI) & ~r_ack;
    assign w_wr  = w_req & wbs.wbs_we_i;
    assign w_off = wbs.wbs_adr_i[4:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_mask[gi*8 +: 8] = {8{wbs.wbs_sel_i[gi]}};
        end
    endgenerate

    assign w_ctrl_wr  = (32'(r_ctrl)  & ~w_lane_mask) | (wbs.wbs_dat_i & w_lane_mask);
    assign w_limit_wr = (32'(r_limit) & ~w_lane_mask) | (wbs.wbs_dat_i & w_lane_mask);
    assign w_load_wr  = (32'(r_count) & ~w_lane_mask) | (wbs.wbs_dat_i & w_lane_mask);

    assign w_wr_ctrl  = w_wr && (w_off == OFF_CTRL);
    assign w_wr_load  = w_wr && (w_off == OFF_LOAD);
    assign w_wr_limit = w_wr && (w_off == OFF_LIMIT);
    assign w_w1c      = w_wr && (w_off == OFF_STATUS) && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0];

`ifdef UPDOWN_PRESCALER_EN
    logic [15:0] r_prescale;
    logic [15:0] r_pcnt;
    logic [31:0] w_prescale_wr;
    logic        w_wr_prescale;

    assign w_prescale_wr = (32'(r_prescale) & ~w_lane_mask) | (wbs.wbs_dat_i & w_lane_mask);
    assign w_wr_prescale = w_wr && (w_off == OFF_PRESCALE);
    assign w_tick        = r_ctrl[0] && (r_pcnt == r_prescale);
    assign w_prescale_rd = 32'(r_prescale);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            if (w_wr_prescale) begin
                r_prescale <= w_prescale_wr[15:0];
            end
            if (!r_ctrl[0] || w_wr_prescale || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
            end
        end
    end

    logic w_unused_presc;
    assign w_unused_presc = &{1'b0, w_prescale_wr};
`else
    assign w_tick        = r_ctrl[0];
    assign w_prescale_rd = '0;
`endif

    // LOAD beats a tick in the same cycle, and a suppressed tick cannot raise WRAP.
    always_comb begin
        w_count_next = r_count;
        w_wrap_set   = 1'b0;
        if (w_wr_load) begin
            w_count_next = w_load_wr[CNT_W-1:0];
        end else if (w_tick) begin
            if (r_ctrl[1]) begin
                if (r_count < r_limit) begin
                    w_count_next = r_count + CNT_ONE;
                end else begin
                    w_count_next = '0;
                    w_wrap_set   = 1'b1;
                end
            end else begin
                if (r_count != '0) begin
                    w_count_next = r_count - CNT_ONE;
                end else begin
                    w_count_next = r_limit;
                    w_wrap_set   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_CTRL:     w_rd_data = 32'(r_ctrl);
            OFF_LIMIT:    w_rd_data = 32'(r_limit);
            OFF_STATUS:   w_rd_data = 32'(r_wrap);
            OFF_COUNT:    w_rd_data = 32'(r_count);
            OFF_PRESCALE: w_rd_data = w_prescale_rd;
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_ctrl  <= '0;
            r_limit <= '1;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_dat   <= w_req ? w_rd_data : 32'd0;
            if (w_wr_ctrl) begin
                r_ctrl <= w_ctrl_wr[2:0];
            end
            if (w_wr_limit) begin
                r_limit <= w_limit_wr[CNT_W-1:0];
            end
            r_count <= w_count_next;
            r_wrap  <= w_wrap_set | (r_wrap & ~w_w1c);
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

    assign w_count32 = 32'(r_count);
    assign io_out    = w_count32[15:0];
    assign io_oeb    = '0;
    assign user_irq  = {2'b00, r_wrap & r_ctrl[2]};

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, wbs.wbs_adr_i[1:0], w_ctrl_wr, w_limit_wr, w_load_wr, w_count32};
endmodule

// File: tb/tb_updown_counter_wb.sv
// Randomised + directed bench for updown_counter_wb with a cycle-level reference model
// and a queue-based scoreboard that checks every acked transfer and every output cycle.
module tb_updown_counter_wb;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        rst;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic [2:0]  user_irq;

    updown_counter_wb_if bus ();

    updown_counter_wb #(.CNT_W(16), .BASE_ADR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .user_irq (user_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference model: register file as the software sees it plus a free-running phase.
    typedef struct {
        logic [2:0]  ctrl;
        logic [15:0] limit;
        logic [15:0] count;
        bit          wrap;
        logic [15:0] presc;
        int          phase;
        bit          ack;
    } m_t;

    m_t m;
    logic [31:0] exp_q[$];

    function automatic m_t m_reset();
        m_t s;
        s.ctrl = 3'd0; s.limit = 16'hFFFF; s.count = 16'd0; s.wrap = 1'b0;
        s.presc = 16'd0; s.phase = 0; s.ack = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old_v, logic [31:0] dat, logic [3:0] sel);
        logic [31:0] r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = dat[b*8 +: 8];
        return r;
    endfunction

    function automatic bit m_req(m_t s);
        return bus.wbs_stb_i && bus.wbs_cyc_i && (bus.wbs_adr_i[31:5] == BASE[31:5]) && !s.ack;
    endfunction

    function automatic logic [31:0] m_read(m_t s, logic [2:0] off);
        case (off)
            3'd0: return {29'd0, s.ctrl};
            3'd2: return {16'd0, s.limit};
            3'd3: return {31'd0, s.wrap};
            3'd4: return {16'd0, s.count};
`ifdef UPDOWN_PRESCALER_EN
            3'd5: return {16'd0, s.presc};
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic m_t m_step(m_t s);
        m_t n = s;
        bit req, we, tick, ld;
        logic [2:0] off;
        logic [31:0] d;
        int p;
        req = m_req(s);
        we  = req && bus.wbs_we_i;
        off = bus.wbs_adr_i[4:2];
        ld  = we && off == 3'd1;
`ifdef UPDOWN_PRESCALER_EN
        p = int'(s.presc);
`else
        p = 0;
`endif
        tick    = s.ctrl[0] && (s.phase % (p + 1) == p);
        n.phase = s.ctrl[0] ? s.phase + 1 : 0;
        n.wrap  = s.wrap && !(we && off == 3'd3 && bus.wbs_sel_i[0] && bus.wbs_dat_i[0]);
        if (ld) begin
            d = merge({16'd0, s.count}, bus.wbs_dat_i, bus.wbs_sel_i);
            n.count = d[15:0];
        end else if (tick) begin
            if (s.ctrl[1]) begin
                if (s.count < s.limit) n.count = s.count + 16'd1;
                else begin n.count = 16'd0; n.wrap = 1'b1; end
            end else begin
                if (s.count != 16'd0) n.count = s.count - 16'd1;
                else begin n.count = s.limit; n.wrap = 1'b1; end
            end
        end
        if (we && off == 3'd0) begin
            d = merge({29'd0, s.ctrl}, bus.wbs_dat_i, bus.wbs_sel_i);
            n.ctrl = d[2:0];
        end
        if (we && off == 3'd2) begin
            d = merge({16'd0, s.limit}, bus.wbs_dat_i, bus.wbs_sel_i);
            n.limit = d[15:0];
        end
`ifdef UPDOWN_PRESCALER_EN
        if (we && off == 3'd5) begin
            d = merge({16'd0, s.presc}, bus.wbs_dat_i, bus.wbs_sel_i);
            n.presc = d[15:0];
            n.phase = 0;
        end
`endif
        n.ack = req;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m <= m_reset();
        end else begin
            if (m_req(m)) exp_q.push_back(m_read(m, bus.wbs_adr_i[4:2]));
            m <= m_step(m);
        end
    end

    // Monitor: every cycle after reset, compare bus and pins against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ack", {31'd0, bus.wbs_ack_o}, {31'd0, m.ack});
            if (m.ack) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: ack with no expected entry at %0t", $time);
                end else begin
                    check("rdata", bus.wbs_dat_o, exp_q.pop_front());
                end
            end else begin
                check("dat_idle", bus.wbs_dat_o, 32'd0);
            end
            check("io_out", {16'd0, io_out}, {16'd0, m.count});
            check("io_oeb", {16'd0, io_oeb}, 32'd0);
            check("user_irq", {29'd0, user_irq}, {31'd0, m.wrap & m.ctrl[2]});
        end
    end

    task automatic bus_idle();
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    endtask

    task automatic bus_op(input bit we, input logic [2:0] off, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd, output logic [15:0] io);
        int n;
        @(negedge clk);
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_sel_i = sel;  bus.wbs_adr_i = BASE | {27'd0, off, 2'b00};
        bus.wbs_dat_i = dat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wbs_ack_o && n < 4);
        check("ack_latency", n, 1);
        rd = bus.wbs_dat_o;
        io = io_out;
        bus_idle();
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] rd; logic [15:0] io;
        bus_op(1'b1, off, dat, sel, rd, io);
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] data);
        logic [15:0] io;
        bus_op(1'b0, off, 32'd0, 4'hF, data, io);
    endtask

    // Collect the first n distinct successive io_out values, starting at a known sample.
    task automatic watch_runs(input logic [15:0] first, input int nvals,
                              output logic [15:0] vals[8], output int got, output logic [2:0] irq_last);
        logic [15:0] last = first;
        vals[0] = first; got = 1; irq_last = user_irq;
        for (int c = 0; c < 60 && got < nvals; c++) begin
            @(negedge clk);
            if (io_out != last) begin
                vals[got] = io_out; got++; last = io_out; irq_last = user_irq;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [15:0] io;
        logic [15:0] vals[8];
        logic [15:0] exp_up[5];
        logic [15:0] exp_dn[4];
        logic [2:0]  irq;
        int got, changes;
        logic [15:0] prev;

        exp_up = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
        exp_dn = '{16'd0, 16'd5, 16'd4, 16'd3};
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        rst = 1'b0;

        // Reset values.
        rd(3'd4, d); check("reset_count", d, 32'h0);
        rd(3'd2, d); check("reset_limit", d, 32'hFFFF);
        rd(3'd3, d); check("reset_status", d, 32'h0);

        // Request in flight when reset hits is dropped.
        @(negedge clk);
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_adr_i = BASE | 32'h10;
        rst = 1'b1;
        @(negedge clk);
        check("reset_drop_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        bus_idle();
        rst = 1'b0;

        // Byte-lane write into LIMIT.
        wr(3'd2, 32'h1234, 4'b0001);
        rd(3'd2, d); check("limit_sel", d, 32'hFF34);

        // Up-count with wrap and interrupt.
        wr(3'd2, 32'd3);
        wr(3'd1, 32'd0);
        bus_op(1'b1, 3'd0, 32'h7, 4'hF, d, io);
        watch_runs(io, 5, vals, got, irq);
        check("up_runs", got, 5);
        for (int i = 0; i < 5; i++) check($sformatf("up_seq%0d", i), {16'd0, vals[i]}, {16'd0, exp_up[i]});
        check("up_wrap_irq", {29'd0, irq}, 32'd1);

        // Down-count reload from LIMIT.
        wr(3'd0, 32'h0);
        wr(3'd3, 32'h1);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd5);
        bus_op(1'b1, 3'd0, 32'h1, 4'hF, d, io);
        watch_runs(io, 4, vals, got, irq);
        check("dn_runs", got, 4);
        for (int i = 0; i < 4; i++) check($sformatf("dn_seq%0d", i), {16'd0, vals[i]}, {16'd0, exp_dn[i]});

        // LIMIT=0 wraps on every tick, so a W1C always collides with a set.
        wr(3'd2, 32'd0);
        wr(3'd3, 32'h1);
        rd(3'd3, d); check("wrap_set_wins", d, 32'h1);
        wr(3'd0, 32'h0);
        wr(3'd3, 32'h1);
        rd(3'd3, d); check("wrap_cleared", d, 32'h0);

        // LOAD beats the tick in the same cycle.
        wr(3'd2, 32'hFFFF);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h3);
        bus_op(1'b1, 3'd1, 32'h00AA, 4'hF, d, io);
        check("load_over_tick", {16'd0, io}, 32'h00AA);

        // Prescaler.
        wr(3'd0, 32'h0);
        wr(3'd1, 32'd0);
        wr(3'd5, 32'd2);
        wr(3'd0, 32'h3);
        rd(3'd5, d);
`ifdef UPDOWN_PRESCALER_EN
        check("prescale_rd", d, 32'd2);
`else
        check("prescale_rd", d, 32'd0);
`endif
        prev = io_out; changes = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (io_out != prev) changes++;
            prev = io_out;
        end
`ifdef UPDOWN_PRESCALER_EN
        check("tick_rate", changes, 3);
`else
        check("tick_rate", changes, 9);
`endif

        // Randomised traffic; the monitor checks every cycle against the model.
        for (int t = 0; t < 300; t++) begin
            int kind = int'($urandom_range(0, 11));
            logic [2:0] off = 3'($urandom_range(0, 7));
            logic [31:0] dat = $urandom;
            logic [3:0] sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if (off == 3'd2 && $urandom_range(0, 1) == 1) dat = $urandom_range(0, 6);
            if (off == 3'd1 && $urandom_range(0, 1) == 1) dat = $urandom_range(0, 8);
            if (off == 3'd5) dat = $urandom_range(0, 3);
            if (kind == 0) begin
                @(negedge clk);
                bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_adr_i = BASE ^ 32'h100;
                bus.wbs_we_i = 1'b1; bus.wbs_dat_i = dat; bus.wbs_sel_i = 4'hF;
                repeat (2) @(negedge clk);
                bus_idle();
            end else if (kind == 1) begin
                @(negedge clk);
                bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE | {27'd0, off, 2'b00};
                bus.wbs_we_i = 1'b1; bus.wbs_dat_i = dat; bus.wbs_sel_i = 4'hF;
                @(negedge clk);
                bus_idle();
            end else if (kind == 2) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end else begin
                bus_op(kind[0], off, dat, sel, d, io);
            end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
